// File: rtl/alu_dp_pkg.sv
// alu_dp_pkg: shared datapath widths, ALU opcodes and clear-sweep state type
package alu_dp_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  typedef enum logic {IDLE, SWEEP} clr_state_t;
endpackage

// File: rtl/alu_flag_reg.sv
// alu_flag_reg: carry/overflow status register feeding the ALU carry-in
module alu_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic flag_we,
  input  logic cout_in,
  input  logic v_in,
  output logic carry_q,
  output logic ovf_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flag_we) begin
      carry_q <= cout_in;
      ovf_q   <= v_in;
    end
endmodule

// File: rtl/alu_reg_file.sv
// alu_reg_file: ALU operand register file with r0 hardwired to zero,
// optional write-through bypass, status flags and a sequential clear sweep
module alu_reg_file #(
  parameter int DATA_W = alu_dp_pkg::DATA_W,
  parameter int ADDR_W = alu_dp_pkg::ADDR_W,
  parameter int NREGS  = alu_dp_pkg::NREGS,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              cout_in,
  input  logic              v_in,
  output logic              carry_q,
  output logic              ovf_q,
  input  logic              clr_req,
  output logic              busy
);
  import alu_dp_pkg::clr_state_t;
  import alu_dp_pkg::IDLE;
  import alu_dp_pkg::SWEEP;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  clr_state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] regs [NREGS];
  logic we, byp_a, byp_b;
  assign busy  = state == SWEEP;
  assign we    = wr_en && !busy && wr_addr != '0;
  assign byp_a = BYPASS && we && wr_addr == ra_addr;
  assign byp_b = BYPASS && we && wr_addr == rb_addr;
  // we already excludes address 0, so bypass can never leak a value into r0
  assign ra_data = ra_addr == '0 ? '0 : byp_a ? wr_data : regs[ra_addr];
  assign rb_data = rb_addr == '0 ? '0 : byp_b ? wr_data : regs[rb_addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (clr_req) begin
        state_n = SWEEP;
        cnt_n   = ADDR_W'(1);
      end
    end else begin
      cnt_n = cnt + ADDR_W'(1);
      if (cnt == LAST) state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) regs <= '{default: '0};
    else if (busy) regs[cnt] <= '0;
    else if (we) regs[wr_addr] <= wr_data;
  alu_flag_reg u_flags (
    .clk     (clk),
    .rst     (rst),
    .flag_we (flag_we),
    .cout_in (cout_in),
    .v_in    (v_in),
    .carry_q (carry_q),
    .ovf_q   (ovf_q)
  );
endmodule

// File: doc/alu_reg_file.md
Name: alu_reg_file

Overview:
- General-purpose register file that sits directly upstream of the 16-bit ALU in the single-cycle datapath.
- Supplies the ALU's X/Y operands from two combinational read ports and accepts the ALU result via one synchronous write port.
- Holds the carry/overflow status register; its carry bit feeds the ALU's carry-in.
- Provides a sequential clear sweep for soft re-initialisation without asserting reset.

Parameters:
- DATA_W, 16, register and operand width; matches the ALU operand width.
- ADDR_W, 3, register address width.
- NREGS, 8, number of registers; must equal 2**ADDR_W.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports (write-through).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra_addr  in  ADDR_W  read port A address (operand X).
- rb_addr  in  ADDR_W  read port B address (operand Y).
- ra_data  out  DATA_W  read port A data, drives ALU X.
- rb_data  out  DATA_W  read port B data, drives ALU Y.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data, from ALU out.
- flag_we  in  1  capture status flags this cycle.
- cout_in  in  1  ALU Cout.
- v_in  in  1  ALU V.
- carry_q  out  1  stored carry flag, drives ALU Cin.
- ovf_q  out  1  stored overflow flag.
- clr_req  in  1  start a clear sweep.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async, active-high): all registers, carry_q, ovf_q and busy go to 0; the FSM goes to IDLE; the sweep counter goes to 0. Reset asserted mid-sweep aborts the sweep immediately.
- Register 0 is hardwired to 0:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including under bypass.
- Reads are combinational with zero latency. ra_data = reg[ra_addr]; rb_data = reg[rb_addr].
- Write timing: when wr_en=1, busy=0 and wr_addr!=0, reg[wr_addr] <= wr_data on the rising edge. The new value is visible at the read ports after that edge.
- Bypass (BYPASS=1): if wr_en=1, busy=0, wr_addr!=0 and wr_addr equals a read address, that port returns wr_data in the same cycle. With BYPASS=0 the read returns the old value.
- Flags: when flag_we=1, carry_q <= cout_in and ovf_q <= v_in on the edge. Otherwise they hold.
  - flag_we is honoured even while busy.
  - The clear sweep never touches the flags.
- Clear FSM, two states:
  - IDLE: busy=0. clr_req=1 moves to SWEEP with counter=1.
  - SWEEP: busy=1. Each cycle reg[counter] <= 0 and the counter increments. After the cycle that clears register NREGS-1, the FSM returns to IDLE.
  - Registers 1..7 take 7 cycles; busy is high for exactly NREGS-1 cycles.
- Arbitration while busy: wr_en is ignored (the write is dropped, not queued), bypass is disabled, and clr_req is ignored.
- clr_req and wr_en in the same IDLE cycle: the write commits on that edge, and the sweep starts and later clears it.
- Read ports stay live during the sweep and show partially cleared contents.
- Widths: all data is unsigned DATA_W, with no arithmetic inside the block apart from the ADDR_W-bit sweep counter. The counter is sized so that NREGS-1 is reachable without wrapping.

Decomposition:
- Shared package alu_dp_pkg holds:
  - DATA_W, ADDR_W and NREGS constants.
  - The ALU opcode constants shared with the ALU.
  - A clear-FSM state typedef (IDLE, SWEEP).
- One natural sub-module, alu_flag_reg, holds carry_q/ovf_q with async reset and flag_we.
- The register array, bypass mux and FSM stay in the top level.

Test Plan:
- Reset with all registers preloaded -> ra_data=rb_data=0 for every address, carry_q=0, ovf_q=0, busy=0, asynchronously, before the next edge.
- Write 0x1234 to r3, next cycle read ra_addr=3, rb_addr=3 -> both 0x1234. Write 0xFFFF to r0 -> r0 still reads 0x0000.
- BYPASS=1: wr_en=1, wr_addr=5, wr_data=0xA5A5, ra_addr=5 in the same cycle -> ra_data=0xA5A5 before the edge. BYPASS=0 -> old value.
- flag_we=1, cout_in=1, v_in=0 -> next cycle carry_q=1, ovf_q=0. flag_we=0 with cout_in=0 -> carry_q holds 1.
- Fill r1..r7 with 0x0001..0x0007, pulse clr_req -> busy high for exactly 7 cycles, and r1..r7 read 0 in ascending order. A write to r2 during busy is dropped, and r2 reads 0 afterwards.
- Assert rst on sweep cycle 3 -> busy=0 immediately, all registers 0. A write after release succeeds normally.
